tlb_unit: RTL

- Parametrised next-generation TLB: fully associative, ENTRY_NUM entries, LOOKUP_PORTS independent registered translation ports (fetch, load/store, ...).
- Executes TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB through a valid/ready command interface.
- INVTLB is a multi-cycle sweep of INV_LANES entries per cycle.
- Sits between the CSR file (TLB CSRs in, CSR write-back out) and the IF/MEM address-translation stages.

---
 rtl/tlb_unit_if.sv | 64 ++++++
 rtl/tlb_unit.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_unit_if.sv
// rtl/tlb_unit_if.sv - TLB command, CSR exchange and address-translation signal bundle
// The master side drives commands, CSR state and lookup requests; the slave is the TLB.
interface tlb_unit_if #(
  parameter int ENTRY_NUM    = 16,
  parameter int LOOKUP_PORTS = 2,
  parameter int ASID_WID     = 10,
  parameter int PPN_WID      = 20
);
  localparam int IDX_WID = $clog2(ENTRY_NUM);
  localparam int ELO_WID = PPN_WID + 7;

  logic                         cmd_valid;
  logic                         cmd_ready;
  logic [2:0]                   cmd_op;
  logic [4:0]                   inv_op;
  logic [ASID_WID-1:0]          inv_asid;
  logic [18:0]                  inv_vppn;

  logic [ASID_WID-1:0]          csr_asid;
  logic [18:0]                  csr_ehi_vppn;
  logic [IDX_WID-1:0]           csr_idx;
  logic [5:0]                   csr_ps;
  logic                         csr_ne;
  logic [ELO_WID-1:0]           csr_elo0;
  logic [ELO_WID-1:0]           csr_elo1;
  logic                         csr_is_tlbr;

  logic                         csr_we;
  logic [ASID_WID-1:0]          csr_wr_asid;
  logic [18:0]                  csr_wr_vppn;
  logic [IDX_WID-1:0]           csr_wr_idx;
  logic [5:0]                   csr_wr_ps;
  logic                         csr_wr_ne;
  logic [ELO_WID-1:0]           csr_wr_elo0;
  logic [ELO_WID-1:0]           csr_wr_elo1;

  logic [LOOKUP_PORTS-1:0]         lk_req;
  logic [32*LOOKUP_PORTS-1:0]      lk_vaddr;
  logic [LOOKUP_PORTS-1:0]         lk_hit;
  logic [LOOKUP_PORTS-1:0]         lk_v;
  logic [LOOKUP_PORTS-1:0]         lk_d;
  logic [PPN_WID*LOOKUP_PORTS-1:0] lk_ppn;
  logic [2*LOOKUP_PORTS-1:0]       lk_plv;
  logic [2*LOOKUP_PORTS-1:0]       lk_mat;
  logic [LOOKUP_PORTS-1:0]         lk_ps4m;

  modport master (
    output cmd_valid, cmd_op, inv_op, inv_asid, inv_vppn,
    output csr_asid, csr_ehi_vppn, csr_idx, csr_ps, csr_ne, csr_elo0, csr_elo1, csr_is_tlbr,
    output lk_req, lk_vaddr,
    input  cmd_ready,
    input  csr_we, csr_wr_asid, csr_wr_vppn, csr_wr_idx, csr_wr_ps, csr_wr_ne, csr_wr_elo0, csr_wr_elo1,
    input  lk_hit, lk_v, lk_d, lk_ppn, lk_plv, lk_mat, lk_ps4m
  );

  modport slave (
    input  cmd_valid, cmd_op, inv_op, inv_asid, inv_vppn,
    input  csr_asid, csr_ehi_vppn, csr_idx, csr_ps, csr_ne, csr_elo0, csr_elo1, csr_is_tlbr,
    input  lk_req, lk_vaddr,
    output cmd_ready,
    output csr_we, csr_wr_asid, csr_wr_vppn, csr_wr_idx, csr_wr_ps, csr_wr_ne, csr_wr_elo0, csr_wr_elo1,
    output lk_hit, lk_v, lk_d, lk_ppn, lk_plv, lk_mat, lk_ps4m
  );
endinterface

// File: rtl/tlb_unit.sv
// rtl/tlb_unit.sv - fully associative TLB with registered lookup ports and TLB maintenance commands
// Entries hold elo without the g bit; the entry-wide g is reinserted on TLBRD.
module tlb_unit #(
  parameter int ENTRY_NUM    = 16,
  parameter int LOOKUP_PORTS = 2,
  parameter int INV_LANES    = 4,
  parameter int ASID_WID     = 10,
  parameter int PPN_WID      = 20
) (
  input logic       clk,
  input logic       rst,
  tlb_unit_if.slave bus
);
  localparam int IDX_WID = $clog2(ENTRY_NUM);
  localparam int ELO_WID = PPN_WID + 7;
  localparam int GROUPS  = ENTRY_NUM / INV_LANES;
  localparam int PTR_WID = (GROUPS > 1) ? $clog2(GROUPS) : 1;

  localparam logic [2:0] OP_SRCH = 3'd0;
  localparam logic [2:0] OP_RD   = 3'd1;
  localparam logic [2:0] OP_WR   = 3'd2;
  localparam logic [2:0] OP_FILL = 3'd3;
  localparam logic [2:0] OP_INV  = 3'd4;
  localparam logic [5:0] PS_4K   = 6'd12;
  localparam logic [5:0] PS_4M   = 6'd21;

  typedef enum logic [1:0] {ST_IDLE, ST_RESP, ST_INV_SWEEP} state_t;

  state_t state_q, state_d;

  logic                e_q    [ENTRY_NUM];
  logic                g_q    [ENTRY_NUM];
  logic [ASID_WID-1:0] asid_q [ENTRY_NUM];
  logic [18:0]         vppn_q [ENTRY_NUM];
  logic [5:0]          ps_q   [ENTRY_NUM];
  logic [ELO_WID-2:0]  elo0_q [ENTRY_NUM];
  logic [ELO_WID-2:0]  elo1_q [ENTRY_NUM];

  logic [15:0]         lfsr_q, lfsr_d;
  logic [PTR_WID-1:0]  ptr_q, ptr_d;
  logic [4:0]          inv_op_q, inv_op_d;
  logic [ASID_WID-1:0] inv_asid_q, inv_asid_d;
  logic [18:0]         inv_vppn_q, inv_vppn_d;

  logic                rsp_ne_q, rsp_ne_d;
  logic [IDX_WID-1:0]  rsp_idx_q, rsp_idx_d;
  logic [18:0]         rsp_vppn_q, rsp_vppn_d;
  logic [5:0]          rsp_ps_q, rsp_ps_d;
  logic [ASID_WID-1:0] rsp_asid_q, rsp_asid_d;
  logic [ELO_WID-1:0]  rsp_elo0_q, rsp_elo0_d;
  logic [ELO_WID-1:0]  rsp_elo1_q, rsp_elo1_d;

  logic                cmd_ready, csr_we, wr_en, wr_e;
  logic [IDX_WID-1:0]  wr_idx;
  logic                srch_found;
  logic [IDX_WID-1:0]  srch_idx;
  logic                inv_clr [ENTRY_NUM];

  function automatic logic vppn_eq(input logic [18:0] a, input logic [18:0] b, input logic [5:0] ps);
    if (ps == PS_4M) return a[18:9] == b[18:9];
    return a == b;
  endfunction

  function automatic logic inv_sel(input logic [4:0] op, input logic g, input logic am, input logic vm);
    case (op)
      5'd0, 5'd1: return 1'b1;
      5'd2:       return g;
      5'd3:       return ~g;
      5'd4:       return ~g & am;
      5'd5:       return ~g & am & vm;
      5'd6:       return (g | am) & vm;
      default:    return 1'b0;
    endcase
  endfunction

  // 16-bit maximal-length Fibonacci LFSR (x^16+x^14+x^13+x^11+1); low bits pick the FILL victim.
  assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  always_comb begin
    srch_found = 1'b0;
    srch_idx   = '0;
    for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
      if (e_q[i] && (g_q[i] || asid_q[i] == bus.csr_asid) &&
          vppn_eq(vppn_q[i], bus.csr_ehi_vppn, ps_q[i])) begin
        srch_found = 1'b1;
        srch_idx   = IDX_WID'(i);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < ENTRY_NUM; i++) begin
      inv_clr[i] = (state_q == ST_INV_SWEEP) && ((i / INV_LANES) == int'(ptr_q)) &&
                   inv_sel(inv_op_q, g_q[i], asid_q[i] == inv_asid_q,
                           vppn_eq(vppn_q[i], inv_vppn_q, ps_q[i]));
    end
  end

  assign wr_idx = (bus.cmd_op == OP_FILL) ? lfsr_q[IDX_WID-1:0] : bus.csr_idx;
  assign wr_e   = bus.csr_is_tlbr ? ~bus.csr_ne : 1'b1;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    inv_op_d   = inv_op_q;
    inv_asid_d = inv_asid_q;
    inv_vppn_d = inv_vppn_q;
    rsp_ne_d   = rsp_ne_q;
    rsp_idx_d  = rsp_idx_q;
    rsp_vppn_d = rsp_vppn_q;
    rsp_ps_d   = rsp_ps_q;
    rsp_asid_d = rsp_asid_q;
    rsp_elo0_d = rsp_elo0_q;
    rsp_elo1_d = rsp_elo1_q;
    cmd_ready  = 1'b0;
    csr_we     = 1'b0;
    wr_en      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          case (bus.cmd_op)
            OP_SRCH: begin
              rsp_ne_d  = ~srch_found;
              rsp_idx_d = srch_found ? srch_idx : bus.csr_idx;
              state_d   = ST_RESP;
            end
            OP_RD: begin
              rsp_idx_d = bus.csr_idx;
              state_d   = ST_RESP;
              if (e_q[bus.csr_idx]) begin
                rsp_ne_d   = 1'b0;
                rsp_vppn_d = vppn_q[bus.csr_idx];
                rsp_ps_d   = ps_q[bus.csr_idx];
                rsp_asid_d = asid_q[bus.csr_idx];
                rsp_elo0_d = {elo0_q[bus.csr_idx][ELO_WID-2:6], g_q[bus.csr_idx], elo0_q[bus.csr_idx][5:0]};
                rsp_elo1_d = {elo1_q[bus.csr_idx][ELO_WID-2:6], g_q[bus.csr_idx], elo1_q[bus.csr_idx][5:0]};
              end else begin
                rsp_ne_d   = 1'b1;
                rsp_vppn_d = '0;
                rsp_ps_d   = '0;
                rsp_asid_d = '0;
                rsp_elo0_d = '0;
                rsp_elo1_d = '0;
              end
            end
            OP_WR, OP_FILL: wr_en = 1'b1;
            OP_INV: begin
              inv_op_d   = bus.inv_op;
              inv_asid_d = bus.inv_asid;
              inv_vppn_d = bus.inv_vppn;
              ptr_d      = '0;
              state_d    = ST_INV_SWEEP;
            end
            default: ;
          endcase
        end
      end
      ST_RESP: begin
        csr_we  = 1'b1;
        state_d = ST_IDLE;
      end
      ST_INV_SWEEP: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == PTR_WID'(GROUPS - 1)) begin
          ptr_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      lfsr_q     <= 16'h0001;
      ptr_q      <= '0;
      inv_op_q   <= '0;
      inv_asid_q <= '0;
      inv_vppn_q <= '0;
      rsp_ne_q   <= 1'b0;
      rsp_idx_q  <= '0;
      rsp_vppn_q <= '0;
      rsp_ps_q   <= '0;
      rsp_asid_q <= '0;
      rsp_elo0_q <= '0;
      rsp_elo1_q <= '0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      ptr_q      <= ptr_d;
      inv_op_q   <= inv_op_d;
      inv_asid_q <= inv_asid_d;
      inv_vppn_q <= inv_vppn_d;
      rsp_ne_q   <= rsp_ne_d;
      rsp_idx_q  <= rsp_idx_d;
      rsp_vppn_q <= rsp_vppn_d;
      rsp_ps_q   <= rsp_ps_d;
      rsp_asid_q <= rsp_asid_d;
      rsp_elo0_q <= rsp_elo0_d;
      rsp_elo1_q <= rsp_elo1_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRY_NUM; i++) e_q[i] <= 1'b0;
    end else begin
      for (int i = 0; i < ENTRY_NUM; i++) begin
        if (wr_en && wr_idx == IDX_WID'(i)) e_q[i] <= wr_e;
        else if (inv_clr[i])                e_q[i] <= 1'b0;
      end
    end
  end

  // Payload fields are meaningless while e=0, so they carry no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      g_q[wr_idx]    <= bus.csr_elo0[6] & bus.csr_elo1[6];
      asid_q[wr_idx] <= bus.csr_asid;
      vppn_q[wr_idx] <= bus.csr_ehi_vppn;
      ps_q[wr_idx]   <= bus.csr_ps;
      elo0_q[wr_idx] <= {bus.csr_elo0[ELO_WID-1:7], bus.csr_elo0[5:0]};
      elo1_q[wr_idx] <= {bus.csr_elo1[ELO_WID-1:7], bus.csr_elo1[5:0]};
    end
  end

  logic [LOOKUP_PORTS-1:0]         lk_found, lk_odd;
  logic [IDX_WID-1:0]              lk_idx [LOOKUP_PORTS];
  logic [ELO_WID-2:0]              lk_elo [LOOKUP_PORTS];
  logic [LOOKUP_PORTS-1:0]         lk_hit_q, lk_v_q, lk_d_q, lk_ps4m_q;
  logic [PPN_WID*LOOKUP_PORTS-1:0] lk_ppn_q;
  logic [2*LOOKUP_PORTS-1:0]       lk_plv_q, lk_mat_q;
  logic                            lk_vaddr_unused;

  always_comb begin
    lk_found        = '0;
    lk_odd          = '0;
    lk_vaddr_unused = 1'b0;
    for (int p = 0; p < LOOKUP_PORTS; p++) begin
      lk_idx[p] = '0;
      for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
        if (e_q[i] && (g_q[i] || asid_q[i] == bus.csr_asid) &&
            vppn_eq(vppn_q[i], bus.lk_vaddr[32*p+13 +: 19], ps_q[i])) begin
          lk_found[p] = 1'b1;
          lk_idx[p]   = IDX_WID'(i);
        end
      end
      lk_odd[p] = (ps_q[lk_idx[p]] == PS_4M) ? bus.lk_vaddr[32*p+21] : bus.lk_vaddr[32*p+12];
      lk_elo[p] = lk_odd[p] ? elo1_q[lk_idx[p]] : elo0_q[lk_idx[p]];
      lk_vaddr_unused = lk_vaddr_unused ^ (^bus.lk_vaddr[32*p +: 12]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lk_hit_q  <= '0;
      lk_v_q    <= '0;
      lk_d_q    <= '0;
      lk_ps4m_q <= '0;
      lk_ppn_q  <= '0;
      lk_plv_q  <= '0;
      lk_mat_q  <= '0;
    end else begin
      for (int p = 0; p < LOOKUP_PORTS; p++) begin
        lk_hit_q[p] <= bus.lk_req[p] & lk_found[p];
        if (bus.lk_req[p]) begin
          lk_v_q[p]                      <= lk_found[p] & lk_elo[p][0];
          lk_d_q[p]                      <= lk_found[p] & lk_elo[p][1];
          lk_plv_q[2*p +: 2]             <= lk_found[p] ? lk_elo[p][3:2] : 2'b00;
          lk_mat_q[2*p +: 2]             <= lk_found[p] ? lk_elo[p][5:4] : 2'b00;
          lk_ppn_q[PPN_WID*p +: PPN_WID] <= lk_found[p] ? lk_elo[p][ELO_WID-2:6] : '0;
          lk_ps4m_q[p]                   <= lk_found[p] & (ps_q[lk_idx[p]] != PS_4K);
        end
      end
    end
  end

  assign bus.cmd_ready   = cmd_ready;
  assign bus.csr_we      = csr_we;
  assign bus.csr_wr_ne   = rsp_ne_q;
  assign bus.csr_wr_idx  = rsp_idx_q;
  assign bus.csr_wr_vppn = rsp_vppn_q;
  assign bus.csr_wr_ps   = rsp_ps_q;
  assign bus.csr_wr_asid = rsp_asid_q;
  assign bus.csr_wr_elo0 = rsp_elo0_q;
  assign bus.csr_wr_elo1 = rsp_elo1_q;
  assign bus.lk_hit      = lk_hit_q;
  assign bus.lk_v        = lk_v_q;
  assign bus.lk_d        = lk_d_q;
  assign bus.lk_ppn      = lk_ppn_q;
  assign bus.lk_plv      = lk_plv_q;
  assign bus.lk_mat      = lk_mat_q;
  assign bus.lk_ps4m     = lk_ps4m_q;
endmodule
